// File: rtl/frame_stream_reader_if.sv
// Frame RAM read port plus tagged pixel stream (sof/eol/eof) for the raster reader.
// Latency: none; this file holds wires only.
// Backpressure: pixel_ready from the sink stalls the stream; the RAM port has no backpressure.
//
// Ports (master = reader side, slave = RAM and downstream side):
//   mem_rd_en, mem_addr   reader -> RAM   read strobe and address
//   mem_rd_data           RAM -> reader   data one cycle after mem_rd_en
//   pixel_out, pixel_valid, sof, eol, eof   reader -> sink
//   pixel_ready           sink -> reader
interface frame_stream_reader_if #(
  parameter int WORD_SIZE = 24,
  parameter int ADDR_W    = 18
);
  logic                 mem_rd_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [WORD_SIZE-1:0] mem_rd_data;
  logic [WORD_SIZE-1:0] pixel_out;
  logic                 pixel_valid;
  logic                 pixel_ready;
  logic                 sof;
  logic                 eol;
  logic                 eof;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output pixel_out, pixel_valid, sof, eol, eof,
    input  pixel_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  pixel_out, pixel_valid, sof, eol, eof,
    output pixel_ready
  );
endinterface

// File: rtl/frame_stream_reader.sv
// Raster-scan frame reader: streams a stored frame row-major, one pixel per cycle, with sof/eol/eof tags.
// Latency: start sampled at edge 0 -> read addr 0 after edge 0 -> pixel_valid after edge 2.
// Backpressure: 2-entry skid FIFO; reads stop while FIFO + in-flight would exceed 2, resume on a pop.
//
// Ports: clock, reset (sync, active-high), start (pulse), busy, done (pulse),
//        bus (frame_stream_reader_if.master: RAM read port + pixel stream).
// Optional feature: define FLUSH_PAD_EN to append ROW_SIZE+2 zero pixels (tags 0) after the frame,
// pushing the final rows through the downstream 3x3 window before done.

// Small generic FIFO: registered storage, head is visible combinationally while not empty.
// Latency: data pushed at an edge is at the head after that edge when the FIFO was empty.
// Backpressure: push is dropped when full unless a pop frees the slot in the same cycle.
module frame_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_dat,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module frame_stream_reader #(
  parameter int WORD_SIZE = 24,
  parameter int ROW_SIZE  = 512,
  parameter int NUM_ROWS  = 512,
  parameter int ADDR_W    = $clog2(ROW_SIZE * NUM_ROWS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  frame_stream_reader_if.master  bus
);
  localparam int COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(NUM_ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(ROW_SIZE);

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } tags_t;

  typedef struct packed {
    tags_t                tags;
    logic [WORD_SIZE-1:0] dat;
  } pix_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
`ifdef FLUSH_PAD_EN
    S_FLUSH,
`endif
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             inflight_q, inflight_d;        // a read was issued last cycle
  tags_t            inflight_tags_q, inflight_tags_d;

`ifdef FLUSH_PAD_EN
  localparam int PAD_W = $clog2(ROW_SIZE + 2);
  localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(ROW_SIZE + 1);
  logic [PAD_W-1:0] pad_cnt_q, pad_cnt_d;
`endif

  pix_t       fifo_head, fifo_push_dat;
  logic       fifo_empty, fifo_pop;
  logic [1:0] fifo_count;
  logic [2:0] occ_after_pop;
  logic       rd_issue, last_addr, drain_clear;
  tags_t      issue_tags;

  assign fifo_push_dat = '{tags: inflight_tags_q, dat: bus.mem_rd_data};

  frame_stream_fifo #(
    .WIDTH ($bits(pix_t)),
    .DEPTH (2)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .push     (inflight_q),
    .push_dat (fifo_push_dat),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign last_addr      = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign issue_tags.sof = (row_q == '0) && (col_q == '0);
  assign issue_tags.eol = (col_q == LAST_COL);
  assign issue_tags.eof = last_addr;

  // The slot freed by this cycle's pop counts as available, so a steady ready=1 stream
  // keeps one read per cycle with no bubbles while never exceeding two entries.
  assign occ_after_pop = 3'(fifo_count) + 3'(inflight_q) - 3'(fifo_pop);
  assign rd_issue      = (state_q == S_READ) && (occ_after_pop < 3'd2);

  // Leave DRAIN once the FIFO goes empty at this edge and nothing is still returning.
  assign drain_clear = !inflight_q &&
                       ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && fifo_pop));

  assign bus.mem_rd_en = rd_issue;
  assign bus.mem_addr  = ADDR_W'(row_q) * ROW_STRIDE + ADDR_W'(col_q);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

  always_comb begin
    bus.pixel_valid = !fifo_empty;
    bus.pixel_out   = fifo_head.dat;
    bus.sof         = fifo_head.tags.sof;
    bus.eol         = fifo_head.tags.eol;
    bus.eof         = fifo_head.tags.eof;
    fifo_pop        = !fifo_empty && bus.pixel_ready;
`ifdef FLUSH_PAD_EN
    if (state_q == S_FLUSH) begin
      bus.pixel_valid = 1'b1;
      bus.pixel_out   = '0;
      bus.sof         = 1'b0;
      bus.eol         = 1'b0;
      bus.eof         = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d         = state_q;
    row_d           = row_q;
    col_d           = col_q;
    inflight_d      = rd_issue;
    inflight_tags_d = issue_tags;
`ifdef FLUSH_PAD_EN
    pad_cnt_d       = pad_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_READ: begin
        if (rd_issue) begin
          if (last_addr) begin
            state_d = S_DRAIN;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_clear) begin
`ifdef FLUSH_PAD_EN
          state_d   = S_FLUSH;
          pad_cnt_d = '0;
`else
          state_d   = S_DONE;
`endif
        end
      end
`ifdef FLUSH_PAD_EN
      S_FLUSH: begin
        if (bus.pixel_ready) begin
          if (pad_cnt_q == PAD_LAST) state_d = S_DONE;
          else                       pad_cnt_d = pad_cnt_q + PAD_W'(1);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      row_q           <= '0;
      col_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_tags_q <= '0;
`ifdef FLUSH_PAD_EN
      pad_cnt_q       <= '0;
`endif
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      col_q           <= col_d;
      inflight_q      <= inflight_d;
      inflight_tags_q <= inflight_tags_d;
`ifdef FLUSH_PAD_EN
      pad_cnt_q       <= pad_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_frame_stream_reader.sv
// Bench for frame_stream_reader with a 4x3 frame; behavioural model is the expected pixel list.
// Latency: checks first valid 2 cycles after start and done 1 cycle after the last transfer.
// Backpressure: ready held high, toggled 1,0,0,1, held low, and randomized.
module tb_frame_stream_reader;
  localparam int W    = 24;
  localparam int ROW  = 4;
  localparam int ROWS = 3;
  localparam int N    = ROW * ROWS;
  localparam int AW   = 4;
`ifdef FLUSH_PAD_EN
  localparam int TOTAL = N + ROW + 2;
`else
  localparam int TOTAL = N;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  frame_stream_reader_if #(.WORD_SIZE(W), .ADDR_W(AW)) bus();

  frame_stream_reader #(
    .WORD_SIZE (W),
    .ROW_SIZE  (ROW),
    .NUM_ROWS  (ROWS),
    .ADDR_W    (AW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Frame RAM model: sync read, data valid the cycle after the strobe.
  logic [W-1:0] mem [N];
  always @(posedge clock) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  int checks = 0;
  int passed = 0;
  int idx = 0;          // transfers seen in the current frame
  int issued = 0;       // reads issued in the current frame
  int cyc = 0;
  int last_xfer_cyc = 0;
  int done_count = 0;
  int ready_mode = 0;   // 0 high, 1 pattern 1,0,0,1, 2 random, 3 low
  int pat_cnt = 0;
  bit prev_stall = 0;
  bit prev_done = 0;
  logic [W-1:0] held_dat;
  logic [2:0]   held_tags;

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected stream from the frame definition: k-th pixel of row-major order, then zero pads.
  function automatic logic [W-1:0] exp_dat(input int k);
    return (k < N) ? mem[k] : '0;
  endfunction

  function automatic logic [2:0] exp_tags(input int k);
    logic [2:0] t;
    t[2] = (k == 0);
    t[1] = (k < N) && ((k % ROW) == ROW - 1);
    t[0] = (k == N - 1);
    return t;
  endfunction

  // Single compare process: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    int frame_x;
    cyc++;
    if (reset) begin
      idx = 0;
      issued = 0;
      prev_stall = 0;
      prev_done = 0;
    end else begin
      if (prev_done) check_eq("busy_after_done", busy, 0);
      if (bus.mem_rd_en) begin
        check_eq("rd_addr", bus.mem_addr, issued);
        issued++;
      end
      if (bus.pixel_valid) begin
        if (prev_stall) begin
          check_eq("hold_dat", bus.pixel_out, held_dat);
          check_eq("hold_tags", {bus.sof, bus.eol, bus.eof}, held_tags);
        end
        if (bus.pixel_ready) begin
          check_eq("xfer_in_range", idx < TOTAL, 1);
          check_eq("pix_dat", bus.pixel_out, exp_dat(idx));
          check_eq("pix_tags", {bus.sof, bus.eol, bus.eof}, exp_tags(idx));
          idx++;
          last_xfer_cyc = cyc;
        end
      end
      if (ready_mode == 0 && idx > 0 && idx < TOTAL && busy)
        check_eq("no_bubble", bus.pixel_valid, 1);
      if (busy) begin
        frame_x = (idx < N) ? idx : N;
        check_eq("outstanding_le2", (issued - frame_x) <= 2, 1);
      end
      prev_stall = bus.pixel_valid && !bus.pixel_ready;
      held_dat   = bus.pixel_out;
      held_tags  = {bus.sof, bus.eol, bus.eof};
      if (done) begin
        done_count++;
        check_eq("done_xfers", idx, TOTAL);
        check_eq("done_after_last", cyc - last_xfer_cyc, 1);
      end
      prev_done = done;
      if (start && !busy) begin
        idx = 0;
        issued = 0;
        prev_stall = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    case (ready_mode)
      0: bus.pixel_ready = 1'b1;
      1: begin
        bus.pixel_ready = ((pat_cnt % 4) == 0) || ((pat_cnt % 4) == 3);
        pat_cnt++;
      end
      2: bus.pixel_ready = 1'($urandom_range(0, 1));
      default: bus.pixel_ready = 1'b0;
    endcase
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idx(input int n, input int budget);
    int k = 0;
    while (idx < n && k < budget) begin
      tick();
      k++;
    end
    check_eq("wait_idx_reached", idx >= n, 1);
  endtask

  task automatic wait_done(input int budget, output int ticks);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    ticks = k;
    check_eq("done_seen", done, 1);
  endtask

  task automatic fill_linear();
    for (int i = 0; i < N; i++) mem[i] = W'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = W'($urandom);
  endtask

  initial begin
    int t;
    int dc0;
    bus.pixel_ready = 1'b0;
    fill_linear();

    // Reset state
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd_en", bus.mem_rd_en, 0);
    check_eq("rst_addr", bus.mem_addr, 0);
    check_eq("rst_valid", bus.pixel_valid, 0);
    check_eq("rst_pixel", bus.pixel_out, 0);
    check_eq("rst_tags", {bus.sof, bus.eol, bus.eof}, 0);
    reset = 1'b0;
    tick();
    check_eq("idle_busy", busy, 0);

    // Full-rate frame: latency and done timing pinned literally
    ready_mode = 0;
    tick();
    pulse_start();
    check_eq("lat_rd_en", bus.mem_rd_en, 1);
    check_eq("lat_addr0", bus.mem_addr, 0);
    tick();
    check_eq("lat_busy", busy, 1);
    check_eq("lat_valid_e1", bus.pixel_valid, 0);
    tick();
    check_eq("lat_valid_e2", bus.pixel_valid, 1);
    check_eq("lat_pix0", bus.pixel_out, 0);
    check_eq("lat_sof", bus.sof, 1);
    wait_done(200, t);
    check_eq("done_edge", t + 2, TOTAL + 2);
    tick();
    check_eq("idle_after_done", busy, 0);

    // ready 1,0,0,1 repeating
    repeat (2) tick();
    ready_mode = 1;
    pat_cnt = 0;
    pulse_start();
    wait_done(300, t);
    ready_mode = 0;
    repeat (2) tick();

    // ready low from start: exactly two reads, head held at pixel 0
    ready_mode = 3;
    tick();
    pulse_start();
    repeat (10) tick();
    check_eq("stall_reads", issued, 2);
    check_eq("stall_valid", bus.pixel_valid, 1);
    check_eq("stall_pix", bus.pixel_out, 0);
    check_eq("stall_sof", bus.sof, 1);
    ready_mode = 0;
    wait_done(200, t);
    repeat (2) tick();

    // start re-pulsed mid-frame is ignored
    pulse_start();
    wait_idx(5, 100);
    dc0 = done_count;
    pulse_start();
    wait_done(200, t);
    repeat (3) tick();
    check_eq("single_done", done_count - dc0, 1);

    // reset mid-frame, then restart with random data and random ready
    pulse_start();
    wait_idx(6, 100);
    dc0 = done_count;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_valid", bus.pixel_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_rd_en", bus.mem_rd_en, 0);
    repeat (5) tick();
    check_eq("abort_no_done", done_count - dc0, 0);
    fill_random();
    ready_mode = 2;
    pulse_start();
    wait_done(400, t);
    check_eq("restart_xfers", idx, TOTAL);

    // Randomized frames
    for (int f = 0; f < 4; f++) begin
      repeat (1 + $urandom_range(0, 3)) tick();
      fill_random();
      pulse_start();
      wait_done(400, t);
    end
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
